// File: rtl/io_handshake_unit.sv
// io_handshake_unit: FIFO-buffered core I/O port.
// Runs the four-phase device handshakes on both sides autonomously.
module io_handshake_unit #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             in_en,
   input  logic             in_pop,
   output logic [WIDTH-1:0] in_rdata,
   output logic             in_empty,
   output logic [CW-1:0]    in_count,
   input  logic             out_push,
   input  logic [WIDTH-1:0] out_wdata,
   output logic             out_full,
   output logic [CW-1:0]    out_count,
   input  logic             clr_err,
   output logic             err_pop,
   output logic             err_push,
   output logic             inp_req,
   input  logic             inp_ack,
   input  logic [WIDTH-1:0] inp_data,
   output logic             out_req,
   input  logic             out_ack,
   output logic [WIDTH-1:0] out_data
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {I_IDLE, I_REQ, I_WAIT_LOW} in_st_t;
   typedef enum logic [1:0] {O_IDLE, O_REQ, O_WAIT_LOW} out_st_t;

   logic [WIDTH-1:0] r_in_mem [DEPTH];
   logic [PW-1:0]    r_in_wp;
   logic [PW-1:0]    r_in_rp;
   logic [CW-1:0]    r_in_cnt;
   in_st_t           r_ist;
   in_st_t           w_ist_nxt;

   logic [WIDTH-1:0] r_out_mem [DEPTH];
   logic [PW-1:0]    r_out_wp;
   logic [PW-1:0]    r_out_rp;
   logic [CW-1:0]    r_out_cnt;
   out_st_t          r_ost;
   out_st_t          w_ost_nxt;

   logic             r_err_pop;
   logic             r_err_push;

   logic             w_in_empty;
   logic             w_in_full;
   logic             w_in_cap;
   logic             w_in_pop;
   logic [CW-1:0]    w_in_cnt_nxt;
   logic             w_out_empty;
   logic             w_out_full;
   logic             w_out_push;
   logic             w_out_dpop;
   logic [CW-1:0]    w_out_cnt_nxt;

   // Core/device events, judged on the counts at the start of the cycle.
   always_comb begin
      w_in_empty    = (r_in_cnt == '0);
      w_in_full     = (r_in_cnt == L_FULL);
      w_in_cap      = (r_ist == I_REQ) && inp_ack;
      w_in_pop      = in_pop && !w_in_empty;
      w_in_cnt_nxt  = r_in_cnt + CW'(w_in_cap) - CW'(w_in_pop);
      w_out_empty   = (r_out_cnt == '0);
      w_out_full    = (r_out_cnt == L_FULL);
      w_out_push    = out_push && !w_out_full;
      w_out_dpop    = (r_ost == O_REQ) && out_ack;
      w_out_cnt_nxt = r_out_cnt + CW'(w_out_push) - CW'(w_out_dpop);
   end

   // Input FIFO storage; contents are don't-care while the count is 0.
   always_ff @(posedge clk) begin
      if (w_in_cap) r_in_mem[r_in_wp] <= inp_data;
   end

   // Input FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         r_in_wp  <= '0;
         r_in_rp  <= '0;
         r_in_cnt <= '0;
      end else begin
         if (w_in_cap) r_in_wp <= r_in_wp + PW'(1);
         if (w_in_pop) r_in_rp <= r_in_rp + PW'(1);
         r_in_cnt <= w_in_cnt_nxt;
      end
   end

   // Input handshake state register.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) r_ist <= I_IDLE;
      else       r_ist <= w_ist_nxt;
   end

   // Input handshake next state; only requests when a slot is free.
   always_comb begin
      w_ist_nxt = r_ist;
      unique case (r_ist)
         I_IDLE:     if (in_en && !w_in_full) w_ist_nxt = I_REQ;
         I_REQ:      if (inp_ack) w_ist_nxt = I_WAIT_LOW;
         I_WAIT_LOW: begin
            if (!inp_ack) begin
               if (in_en && (w_in_cnt_nxt != L_FULL)) w_ist_nxt = I_REQ;
               else                                   w_ist_nxt = I_IDLE;
            end
         end
         default:    w_ist_nxt = I_IDLE;
      endcase
   end

   // Output FIFO storage.
   always_ff @(posedge clk) begin
      if (w_out_push) r_out_mem[r_out_wp] <= out_wdata;
   end

   // Output FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         r_out_wp  <= '0;
         r_out_rp  <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_out_push) r_out_wp <= r_out_wp + PW'(1);
         if (w_out_dpop) r_out_rp <= r_out_rp + PW'(1);
         r_out_cnt <= w_out_cnt_nxt;
      end
   end

   // Output handshake state register.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) r_ost <= O_IDLE;
      else       r_ost <= w_ost_nxt;
   end

   // Output handshake next state; head stays put until the device acks.
   always_comb begin
      w_ost_nxt = r_ost;
      unique case (r_ost)
         O_IDLE:     if (!w_out_empty) w_ost_nxt = O_REQ;
         O_REQ:      if (out_ack) w_ost_nxt = O_WAIT_LOW;
         O_WAIT_LOW: begin
            if (!out_ack) begin
               if (!w_out_empty) w_ost_nxt = O_REQ;
               else              w_ost_nxt = O_IDLE;
            end
         end
         default:    w_ost_nxt = O_IDLE;
      endcase
   end

   // Sticky misuse flags; a new error beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         r_err_pop  <= 1'b0;
         r_err_push <= 1'b0;
      end else begin
         if (in_pop && w_in_empty)    r_err_pop <= 1'b1;
         else if (clr_err)            r_err_pop <= 1'b0;
         if (out_push && w_out_full)  r_err_push <= 1'b1;
         else if (clr_err)            r_err_push <= 1'b0;
      end
   end

   // Moore outputs and combinational FIFO heads.
   always_comb begin
      inp_req   = (r_ist == I_REQ);
      out_req   = (r_ost == O_REQ);
      in_empty  = w_in_empty;
      in_count  = r_in_cnt;
      in_rdata  = w_in_empty ? '0 : r_in_mem[r_in_rp];
      out_full  = w_out_full;
      out_count = r_out_cnt;
      out_data  = w_out_empty ? '0 : r_out_mem[r_out_rp];
      err_pop   = r_err_pop;
      err_push  = r_err_push;
   end

endmodule

// File: tb/tb_io_handshake_unit.sv
// tb_io_handshake_unit: scoreboard bench for io_handshake_unit.
// Expected words are queued when driven and compared when delivered.
module tb_io_handshake_unit;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_b = 1'b1;
   logic             in_en = 1'b0;
   logic             in_pop = 1'b0;
   logic [WIDTH-1:0] in_rdata;
   logic             in_empty;
   logic [CW-1:0]    in_count;
   logic             out_push = 1'b0;
   logic [WIDTH-1:0] out_wdata = '0;
   logic             out_full;
   logic [CW-1:0]    out_count;
   logic             clr_err = 1'b0;
   logic             err_pop;
   logic             err_push;
   logic             inp_req;
   logic             inp_ack = 1'b0;
   logic [WIDTH-1:0] inp_data = '0;
   logic             out_req;
   logic             out_ack = 1'b0;
   logic [WIDTH-1:0] out_data;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] in_q[$];
   logic [WIDTH-1:0] out_q[$];

   io_handshake_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_b(rst_b),
      .in_en(in_en), .in_pop(in_pop), .in_rdata(in_rdata),
      .in_empty(in_empty), .in_count(in_count),
      .out_push(out_push), .out_wdata(out_wdata),
      .out_full(out_full), .out_count(out_count),
      .clr_err(clr_err), .err_pop(err_pop), .err_push(err_push),
      .inp_req(inp_req), .inp_ack(inp_ack), .inp_data(inp_data),
      .out_req(out_req), .out_ack(out_ack), .out_data(out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ireq();
      int n;
      n = 0;
      while (!inp_req && n < 20) begin
         tick();
         n++;
      end
      chk("ireq_wait", {31'd0, inp_req}, 32'd1);
   endtask

   // Device acks one word: request seen, ack high one cycle, then low.
   task automatic in_xfer(input logic [WIDTH-1:0] w);
      wait_ireq();
      inp_ack  = 1'b1;
      inp_data = w;
      in_q.push_back(w);
      tick();
      chk("ireq_fall", {31'd0, inp_req}, 32'd0);
      inp_ack = 1'b0;
      tick();
   endtask

   task automatic drain_in();
      int n;
      n = 0;
      while (in_q.size() > 0 && n < 20) begin
         chk("in_rdata", 32'(in_rdata), 32'(in_q.pop_front()));
         in_pop = 1'b1;
         tick();
         in_pop = 1'b0;
         n++;
      end
      chk("in_empty", {31'd0, in_empty}, 32'd1);
      chk("in_rdata_e", 32'(in_rdata), 32'd0);
   endtask

   task automatic drain_out();
      int n;
      n = 0;
      while ((out_q.size() > 0 || out_ack) && n < 80) begin
         if (out_ack) begin
            out_ack = 1'b0;
         end else if (out_req) begin
            chk("out_data", 32'(out_data), 32'(out_q.pop_front()));
            out_ack = 1'b1;
         end
         tick();
         n++;
      end
      chk("drain_left", 32'(out_q.size()), 32'd0);
      tick();
      tick();
      chk("out_cnt_end", 32'(out_count), 32'd0);
      chk("oreq_end", {31'd0, out_req}, 32'd0);
   endtask

   initial begin
      logic seen;
      #2;
      chk("rst_ireq", {31'd0, inp_req}, 32'd0);
      chk("rst_oreq", {31'd0, out_req}, 32'd0);
      chk("rst_empty", {31'd0, in_empty}, 32'd1);
      chk("rst_full", {31'd0, out_full}, 32'd0);
      chk("rst_rdata", 32'(in_rdata), 32'd0);
      chk("rst_odata", 32'(out_data), 32'd0);
      tick();
      rst_b = 1'b0;
      tick();

      // Reset in the middle of an output transfer.
      in_pop = 1'b1;
      tick();
      in_pop = 1'b0;
      chk("pre_errpop", {31'd0, err_pop}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         out_push  = 1'b1;
         out_wdata = 16'h7000 + 16'(i);
         tick();
      end
      out_push = 1'b0;
      chk("pre_ocnt", 32'(out_count), 32'd3);
      chk("pre_oreq", {31'd0, out_req}, 32'd1);
      #2;
      rst_b = 1'b1;
      #1;
      chk("mid_oreq", {31'd0, out_req}, 32'd0);
      chk("mid_ocnt", 32'(out_count), 32'd0);
      chk("mid_empty", {31'd0, in_empty}, 32'd1);
      chk("mid_errpop", {31'd0, err_pop}, 32'd0);
      chk("mid_errpush", {31'd0, err_push}, 32'd0);
      tick();
      rst_b = 1'b0;
      tick();

      // Output drain: two consecutive pushes.
      out_push  = 1'b1;
      out_wdata = 16'hA001;
      out_q.push_back(16'hA001);
      tick();
      chk("oreq_lat0", {31'd0, out_req}, 32'd0);
      out_wdata = 16'hA002;
      out_q.push_back(16'hA002);
      tick();
      out_push = 1'b0;
      chk("oreq_lat1", {31'd0, out_req}, 32'd1);
      drain_out();

      // Input fill beyond depth.
      in_en = 1'b1;
      in_xfer(16'h1111);
      in_xfer(16'h2222);
      in_xfer(16'h3333);
      in_xfer(16'h4444);
      chk("fill_cnt", 32'(in_count), 32'd4);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen |= inp_req;
         tick();
      end
      chk("fill_noreq", {31'd0, seen}, 32'd0);
      chk("fill_head", 32'(in_rdata), 32'(in_q.pop_front()));
      in_pop = 1'b1;
      tick();
      in_pop = 1'b0;
      chk("fill_next", 32'(in_rdata), 32'h2222);
      in_xfer(16'h5555);
      chk("refill_cnt", 32'(in_count), 32'd4);
      in_en = 1'b0;
      drain_in();

      // Capture and pop in the same cycle.
      in_en = 1'b1;
      in_xfer(16'hC001);
      in_xfer(16'hC002);
      wait_ireq();
      chk("sim_head", 32'(in_rdata), 32'hC001);
      inp_ack  = 1'b1;
      inp_data = 16'hC003;
      in_q.push_back(16'hC003);
      in_pop   = 1'b1;
      tick();
      void'(in_q.pop_front());
      chk("sim_cnt", 32'(in_count), 32'd2);
      chk("sim_rdata", 32'(in_rdata), 32'(in_q[0]));
      inp_ack = 1'b0;
      in_pop  = 1'b0;
      in_en   = 1'b0;
      tick();
      drain_in();

      // Capture into an empty FIFO with a pop: pop is rejected.
      in_en = 1'b1;
      wait_ireq();
      inp_ack  = 1'b1;
      inp_data = 16'hE001;
      in_q.push_back(16'hE001);
      in_pop   = 1'b1;
      tick();
      chk("ce_errpop", {31'd0, err_pop}, 32'd1);
      chk("ce_cnt", 32'(in_count), 32'd1);
      inp_ack = 1'b0;
      in_pop  = 1'b0;
      in_en   = 1'b0;
      tick();
      drain_in();

      // Slow device with in_en dropped during the wait-low phase.
      in_en = 1'b1;
      wait_ireq();
      inp_ack  = 1'b1;
      inp_data = 16'hD001;
      in_q.push_back(16'hD001);
      tick();
      chk("slow_fall", {31'd0, inp_req}, 32'd0);
      tick();
      in_en = 1'b0;
      tick();
      tick();
      tick();
      inp_ack = 1'b0;
      tick();
      chk("slow_idle", {31'd0, inp_req}, 32'd0);
      tick();
      tick();
      chk("slow_stay", {31'd0, inp_req}, 32'd0);
      chk("slow_cnt", 32'(in_count), 32'd1);
      drain_in();

      // Error flags and overfull pushes.
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("e_clr0", {31'd0, err_pop}, 32'd0);
      in_pop = 1'b1;
      tick();
      in_pop = 1'b0;
      chk("e_pop", {31'd0, err_pop}, 32'd1);
      chk("e_pop_cnt", 32'(in_count), 32'd0);
      for (int i = 0; i < 5; i++) begin
         out_push  = 1'b1;
         out_wdata = 16'hB001 + 16'(i);
         if (i < 4) out_q.push_back(out_wdata);
         tick();
      end
      out_push = 1'b0;
      chk("e_push", {31'd0, err_push}, 32'd1);
      chk("e_ocnt", 32'(out_count), 32'd4);
      chk("e_full", {31'd0, out_full}, 32'd1);
      chk("e_head", 32'(out_data), 32'(out_q[0]));
      chk("e_oreq", {31'd0, out_req}, 32'd1);
      out_ack   = 1'b1;
      out_push  = 1'b1;
      out_wdata = 16'hBEEF;
      clr_err   = 1'b1;
      tick();
      void'(out_q.pop_front());
      out_push = 1'b0;
      chk("e_win", {31'd0, err_push}, 32'd1);
      chk("e_popclr", {31'd0, err_pop}, 32'd0);
      chk("e_ocnt3", 32'(out_count), 32'd3);
      out_ack = 1'b0;
      tick();
      clr_err = 1'b0;
      chk("e_clr", {31'd0, err_push}, 32'd0);
      drain_out();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/io_handshake_unit.md
# io_handshake_unit

Parametrised buffered I/O unit between the CPU core and external input/output devices. It gives the core a FIFO-backed input port and output port of configurable width and depth. It runs the four-phase `inp_req`/`inp_ack` and `out_req`/`out_ack` device handshakes autonomously, so the control unit only pushes and pops words and never stalls inside a handshake.

## Interface
- `WIDTH`, 16, data word width in bits.
- `DEPTH`, 4, entries per FIFO; must be a power of two and at least 2.
- `CW`, `$clog2(DEPTH+1)`, width of the occupancy counts.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_b` input 1: reset, asynchronous and active-high (port keeps the codebase name).
- `in_en` input 1: permits new input requests; a handshake already in flight always completes.
- `in_pop` input 1: core consumes the input-FIFO head this cycle.
- `in_rdata` output WIDTH: input-FIFO head; 0 when empty.
- `in_empty` output 1: input FIFO empty.
- `in_count` output CW: input-FIFO occupancy.
- `out_push` input 1: core writes `out_wdata` into the output FIFO this cycle.
- `out_wdata` input WIDTH: word to enqueue.
- `out_full` output 1: output FIFO full.
- `out_count` output CW: output-FIFO occupancy.
- `clr_err` input 1: clears both error flags.
- `err_pop` output 1: sticky flag; `in_pop` was applied while `in_empty`.
- `err_push` output 1: sticky flag; `out_push` was applied while `out_full`.
- `inp_req` output 1: request to the input device.
- `inp_ack` input 1: input device acknowledge; `inp_data` is valid while it is high.
- `inp_data` input WIDTH: input device word.
- `out_req` output 1: request to the output device; `out_data` is valid while it is high.
- `out_ack` input 1: output device acknowledge.
- `out_data` output WIDTH: output-FIFO head presented to the device.

## Operation
- Both FIFOs are circular register arrays with wrapping read/write pointers and an explicit count.
  - Head words are read combinationally from the array.
  - Full means count == DEPTH; empty means count == 0.
- Input FSM (Moore; `inp_req` = 1 only in I_REQ):
  - I_IDLE → I_REQ when `in_en` && `in_count` < DEPTH.
  - I_REQ: while `inp_ack` = 1, capture `inp_data` into the input FIFO and go to I_WAIT_LOW.
  - I_WAIT_LOW, once `inp_ack` = 0:
    - go to I_REQ if `in_en` && not full (count after this cycle's update);
    - otherwise go to I_IDLE.
  - The FSM never requests a word unless it has room, so the device can never overflow the FIFO.
- Output FSM (Moore; `out_req` = 1 only in O_REQ):
  - O_IDLE → O_REQ when `out_count` > 0.
  - O_REQ: while `out_ack` = 1, pop the head and go to O_WAIT_LOW.
  - O_WAIT_LOW, once `out_ack` = 0: go to O_REQ if non-empty, otherwise O_IDLE.
  - `out_data` = head; it is held stable through O_REQ because only the FSM pops.
- Core side:
  - `in_pop` while empty is ignored and sets `err_pop`.
  - `out_push` while full is ignored and sets `err_push`.
  - Full/empty are evaluated on the count at the start of the cycle. A push to a full output FIFO is rejected even if the device pops in the same cycle.
- Simultaneous events:
  - Device capture plus valid `in_pop`: both occur and `in_count` is unchanged.
  - Capture while empty plus `in_pop`: the pop is rejected and `err_pop` is set; the word stays in the FIFO.
  - Valid `out_push` plus device pop: both occur.
  - `clr_err` together with a new error: the error wins and the flag is set.

## Timing
- Reset, asynchronous and immediate:
  - both FSMs go to IDLE; pointers and counts go to 0;
  - `inp_req` = `out_req` = 0, `err_*` = 0;
  - `in_empty` = 1, `out_full` = 0;
  - `in_rdata` = `out_data` = 0; FIFO contents are discarded.
- Reset mid-handshake drops the request asynchronously; the device must tolerate an early release.
- `inp_req` rises 1 cycle after the I_IDLE enable condition holds.
- A captured word appears on `in_rdata` and in `in_count` 1 cycle after the `inp_ack` sampling edge.
- `out_req` rises 1 cycle after the first push into an empty output FIFO; push-to-device latency is 2 edges.
- Requests fall 1 cycle after the ack is sampled high. The next request rises no earlier than 1 cycle after the ack is sampled low.
- Back-to-back throughput is one word per 2 cycles per direction, assuming a device that acks in 1 cycle.

## Test plan
- Reset mid-transfer:
  - stimulus: assert `rst_b` while `out_req` = 1 and `out_count` = 3;
  - required: `out_req` falls the same cycle, `out_count` = 0, `in_empty` = 1, both error flags = 0.
- Input fill:
  - stimulus: `in_en` = 1, device acks 1 cycle after each request with 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 (DEPTH = 4);
  - required: `in_count` reaches 4 and `inp_req` then stays 0;
  - then: one `in_pop` makes `in_rdata` = 0x2222 and causes a fresh request that captures 0x5555.
- Output drain:
  - stimulus: push 0xA001 and 0xA002 on consecutive cycles;
  - required: `out_data` = 0xA001 while `out_req` = 1; after ack high then low, `out_data` = 0xA002; `out_count` ends at 0 and `out_req` = 0.
- Errors:
  - stimulus: `in_pop` while empty; then `out_push` ×5 with no ack (DEPTH = 4);
  - required: `err_pop` = 1, `err_push` = 1, `out_count` = 4, and the head is still the first pushed word;
  - then: `clr_err` clears both flags.
- Simultaneity:
  - stimulus: input FIFO holds 2 words; a device capture and an `in_pop` occur in the same cycle;
  - required: `in_count` stays 2 and `in_rdata` advances to the second word.
- Slow device and `in_en`:
  - stimulus: hold `inp_ack` high for 5 cycles; deassert `in_en` during I_WAIT_LOW;
  - required: exactly one word is captured, and the FSM returns to I_IDLE with `inp_req` = 0 after ack falls.
